// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the memory-mapped 8N1 UART receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Bit positions of the status flags in the read word.
  localparam int VALID = 8;
  localparam int FERR  = 9;
  localparam int OVR   = 10;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_fifo.sv
// 4x8 receive FIFO; head entry is always presented on dout.
module uart_rx_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  logic [7:0] mem_reg [4];
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg, count_next;
  logic       push_ok, pop_ok;

  assign empty   = (count_reg == 3'd0);
  assign full    = (count_reg == 3'd4);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == 2'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver on the PicoRV32 native bus with read-to-clear status word.
// Define UART_RX_FIFO_EN for a 4-entry receive FIFO instead of a single holding register.
module uart_rx_mmio
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serial_in
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  // Loaded one short so that expiry at zero lands exactly on the counted cycle.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  logic          sync1_reg, rxs_reg;
  rx_state_e     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          push, ferr_set, expire;

  logic          mem_ready_reg, pop_pending_reg;
  logic [31:0]   rdata_reg;
  logic          frame_err_reg, overrun_reg;
  logic          rx_valid, overrun_set, pop, access, is_status;
  logic [7:0]    head;
  logic [31:0]   status_word;
  logic          unused_bus;

  assign unused_bus = ^{mem_instr, mem_wdata, mem_addr[31:4], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= serial_in;
      rxs_reg   <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = (cnt_reg != '0) ? cnt_reg - CW'(1) : cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    push         = 1'b0;
    ferr_set     = 1'b0;
    expire       = (cnt_reg == '0);
    case (state_reg)
      IDLE: begin
        if (!rxs_reg) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (expire) begin
          if (!rxs_reg) begin
            state_next   = DATA;
            cnt_next     = BIT_LOAD;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_next = {rxs_reg, shift_reg[7:1]};
          cnt_next   = BIT_LOAD;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (expire) begin
          push = 1'b1;
          if (rxs_reg) begin
            state_next = IDLE;
          end else begin
            // A low stop sample is taken as the next start bit's mid-point.
            ferr_set     = 1'b1;
            state_next   = DATA;
            cnt_next     = BIT_LOAD;
            bit_idx_next = 3'd0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop = pop_pending_reg;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty, fifo_full;

  uart_rx_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shift_reg),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rx_valid    = ~fifo_empty;
  assign overrun_set = push & fifo_full & ~pop;
`else
  logic       hold_valid_reg;
  logic [7:0] hold_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= 8'h00;
    end else if (push && (!hold_valid_reg || pop)) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= shift_reg;
    end else if (pop) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign rx_valid    = hold_valid_reg;
  assign head        = hold_data_reg;
  assign overrun_set = push & hold_valid_reg & ~pop;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (ferr_set)    frame_err_reg <= 1'b1;
      else if (pop)    frame_err_reg <= 1'b0;
      if (overrun_set) overrun_reg <= 1'b1;
      else if (pop)    overrun_reg <= 1'b0;
    end
  end

  assign access    = enable & mem_valid & ~mem_ready_reg;
  assign is_status = (mem_wstrb == 4'b0000) && (mem_addr[3:2] == 2'b00);

  always_comb begin
    status_word             = 32'h0;
    status_word[OVR]        = overrun_reg;
    status_word[FERR]       = frame_err_reg;
    status_word[VALID]      = rx_valid;
    status_word[7:0]        = rx_valid ? head : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready_reg   <= 1'b0;
      rdata_reg       <= 32'h0;
      pop_pending_reg <= 1'b0;
    end else begin
      mem_ready_reg   <= access;
      rdata_reg       <= (access && is_status) ? status_word : 32'h0;
      pop_pending_reg <= access & is_status & rx_valid;
    end
  end

  assign mem_ready = mem_ready_reg;
  assign mem_rdata = rdata_reg;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio against a queue-based receive model.
module tb_uart_rx_mmio;

  localparam int CPB = 434;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, mem_valid, mem_instr, mem_ready, serial_in;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  logic [31:0] rd;
  logic [7:0]  rb;

  byte unsigned model_q[$];
  bit model_ferr, model_ovr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_mmio #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .serial_in (serial_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    model_q.delete();
    model_ferr = 1'b0;
    model_ovr  = 1'b0;
  endfunction

  function automatic void model_push(input byte unsigned b, input bit ferr);
    if (ferr) model_ferr = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] v;
    if (model_q.size() > 0) begin
      v = {21'b0, model_ovr, model_ferr, 1'b1, model_q.pop_front()};
      model_ferr = 1'b0;
      model_ovr  = 1'b0;
    end else begin
      v = {21'b0, model_ovr, model_ferr, 1'b0, 8'h00};
    end
    return v;
  endfunction

  // Called at a negedge; holds the line for one bit time.
  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit with_start);
    if (with_start) send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    model_push(b, !stop);
    serial_in = 1'b1;
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb, output logic [31:0] data);
    int n;
    n = 0;
    data = 32'h0;
    enable    = 1'b1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = $urandom;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        n = i;
        data = mem_rdata;
        break;
      end
    end
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("ready_latency", 32'(n), 32'd1);
    @(negedge clk);
    check("ready_pulse_end", {31'b0, mem_ready}, 32'd0);
    check("rdata_idle", mem_rdata, 32'h0);
  endtask

  task automatic read_check(input string tag);
    logic [31:0] d;
    bus(32'hFFFF_F050, 4'h0, d);
    check(tag, d, model_read());
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=95000", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_wstrb = 4'h0; mem_wdata = 32'h0; mem_addr = 32'h0; serial_in = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_ready", {31'b0, mem_ready}, 32'd0);
    check("reset_rdata", mem_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    read_check("empty_read");

    send_frame(8'h51, 1'b1, 1'b1);
    read_check("frame_51");
    read_check("second_read");

    send_frame(8'h51, 1'b1, 1'b1);
    send_frame(8'h52, 1'b1, 1'b1);
    read_check("b2b_first");
    read_check("b2b_second");

    // Missing stop bits: each stop slot is the next frame's start bit.
    t0 = cyc;
    fork
      begin
        send_frame(8'h51, 1'b0, 1'b1);
        send_frame(8'h52, 1'b0, 1'b0);
        send_frame(8'h51, 1'b0, 1'b0);
        send_frame(8'h52, 1'b1, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          while (cyc < t0 + (10 + 9 * i) * CPB + CPB / 4) @(negedge clk);
          read_check($sformatf("nostop_%0d", i));
        end
      end
    join
    repeat (CPB) @(negedge clk);
    read_check("nostop_after");

    serial_in = 1'b0;
    repeat (100) @(negedge clk);
    serial_in = 1'b1;
    repeat (CPB) @(negedge clk);
    read_check("glitch");

    send_frame(8'h3C, 1'b1, 1'b1);
    bus(32'hFFFF_F050, 4'hF, rd);
    check("write_ack", rd, 32'h0);
    bus(32'hFFFF_F054, 4'h0, rd);
    check("addr_4", rd, 32'h0);
    bus(32'hFFFF_F05C, 4'h0, rd);
    check("addr_c", rd, 32'h0);

    // Partial 0x52 frame, reset in the middle of bit 4, leftover 0x3C discarded.
    rb = 8'h52;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rb[i]);
    serial_in = rb[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    serial_in = 1'b1;
    model_reset();
    repeat (CPB) @(negedge clk);
    read_check("after_reset");
    send_frame(8'h52, 1'b1, 1'b1);
    read_check("post_reset_52");

    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1'b1);
      repeat ($urandom_range(1, 40)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) read_check($sformatf("rand_%0d", k));
    end
    for (int k = 0; k <= DEPTH; k++) read_check($sformatf("drain_%0d", k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
